mem_test_engine: RTL and testbench

MEM_TEST_ENGINE -- requirements
Module: mem_test_engine

---
 rtl/mem_test_engine_if.sv | 36 +++
 rtl/mem_test_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_test_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_test_engine_if.sv
// Command/response bus between mem_test_engine (master) and the DDR
// controller front end (slave).
interface mem_test_engine_if #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 26,
    parameter int BYTEEN_WIDTH     = 8,
    parameter int BURSTCOUNT_WIDTH = 7
);
    logic                        write;
    logic                        read;
    logic [ADDR_WIDTH-1:0]       address;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [BYTEEN_WIDTH-1:0]     byteenable;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [2:0]                  readdata_sel;
    logic                        cmd_fifo_full;
    logic                        ddr_data_ready;
    logic                        read_ddr_data;
    logic [DATA_WIDTH-1:0]       readdata;
    logic                        ddr_write_timeout;
    logic                        ddr_read_timeout;

    modport master (
        output write, read, address, writedata, byteenable, burstcount,
               readdata_sel, read_ddr_data,
        input  cmd_fifo_full, ddr_data_ready, readdata,
               ddr_write_timeout, ddr_read_timeout
    );

    modport slave (
        input  write, read, address, writedata, byteenable, burstcount,
               readdata_sel, read_ddr_data,
        output cmd_fifo_full, ddr_data_ready, readdata,
               ddr_write_timeout, ddr_read_timeout
    );
endinterface

// File: rtl/mem_test_engine.sv
// Write-then-readback memory test engine with in-order data checking.
// Optional MEM_TEST_ERR_INJECT_EN adds inject_err to flip bit 0 of written data.
module mem_test_engine #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 26,
    parameter int BYTEEN_WIDTH     = 8,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int MAX_OUTSTANDING  = 16,
    parameter int RD_LATENCY       = 4
) (
    input  logic                  Clk_400,
    input  logic                  SoftReset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic [31:0]           seed,
`ifdef MEM_TEST_ERR_INJECT_EN
    input  logic                  inject_err,
`endif
    mem_test_engine_if.master     mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout_err,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]       base_q, num_q, idx_q, pops_q, chk_q;
    logic [31:0]                 seed_q;
    logic [OW-1:0]               outst_q;
    logic [RD_LATENCY-1:0]       vld_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic [BYTEEN_WIDTH-1:0]     be_q;
    logic [BURSTCOUNT_WIDTH-1:0] bc_q;
    logic                        done_q, pass_q, tmo_q;
    logic [15:0]                 err_q;
    logic [ADDR_WIDTH-1:0]       ferr_q;

    logic                  abort, wr_issue, rd_issue, pop, accept, zero_start, finish;
    logic                  chk, mismatch, last_word;
    logic [ADDR_WIDTH-1:0] cur_addr, chk_addr, addr_out;
    logic [DATA_WIDTH-1:0] wdata_c;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [31:0] s);
        return {(DATA_WIDTH/32){s ^ 32'(a)}};
    endfunction

`ifdef MEM_TEST_ERR_INJECT_EN
    assign wdata_c = pattern(cur_addr, seed_q) ^ DATA_WIDTH'(inject_err);
`else
    assign wdata_c = pattern(cur_addr, seed_q);
`endif

    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // A timeout in any active state suppresses commands and pops in that same cycle.
    always_comb begin
        state_d    = state_q;
        abort      = (state_q != IDLE) && (mem.ddr_write_timeout || mem.ddr_read_timeout);
        cur_addr   = base_q + idx_q;
        chk_addr   = base_q + chk_q;
        last_word  = (idx_q == num_q - A_ONE);
        chk        = vld_q[RD_LATENCY-1] && (state_q == READ || state_q == DRAIN);
        mismatch   = chk && (mem.readdata != pattern(chk_addr, seed_q));
        wr_issue   = 1'b0;
        rd_issue   = 1'b0;
        pop        = 1'b0;
        accept     = 1'b0;
        zero_start = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        accept  = 1'b1;
                        state_d = WRITE;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!mem.cmd_fifo_full) begin
                    wr_issue = 1'b1;
                    if (last_word) state_d = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    pop = mem.ddr_data_ready && (pops_q < num_q);
                    if (!mem.cmd_fifo_full && (outst_q < OW'(MAX_OUTSTANDING))) begin
                        rd_issue = 1'b1;
                        if (last_word) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    pop = mem.ddr_data_ready && (pops_q < num_q);
                    if (chk_q == num_q) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            base_q  <= '0;
            num_q   <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            pops_q  <= '0;
            chk_q   <= '0;
            outst_q <= '0;
            vld_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            bc_q    <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            vld_q <= (vld_q << 1) | RD_LATENCY'(pop);
            if (pop) pops_q <= pops_q + A_ONE;
            if (rd_issue && !pop)      outst_q <= outst_q + OW'(1);
            else if (!rd_issue && pop) outst_q <= outst_q - OW'(1);

            if (wr_issue || rd_issue) begin
                addr_q <= cur_addr;
                be_q   <= '1;
                bc_q   <= BURSTCOUNT_WIDTH'(1);
            end
            if (wr_issue) begin
                wdata_q <= wdata_c;
                idx_q   <= last_word ? '0 : idx_q + A_ONE;
            end
            if (rd_issue) idx_q <= idx_q + A_ONE;

            if (chk) chk_q <= chk_q + A_ONE;
            if (mismatch) begin
                if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                if (err_q == '0)       ferr_q <= chk_addr;
            end

            if (finish) begin
                done_q <= 1'b1;
                pass_q <= (err_q == '0);
            end
            if (abort) begin
                done_q <= 1'b1;
                pass_q <= 1'b0;
                tmo_q  <= 1'b1;
                vld_q  <= '0;
            end
            if (zero_start) begin
                done_q <= 1'b1;
                pass_q <= 1'b1;
                tmo_q  <= 1'b0;
                err_q  <= '0;
                ferr_q <= '0;
            end
            if (accept) begin
                base_q  <= base_addr;
                num_q   <= num_words;
                seed_q  <= seed;
                idx_q   <= '0;
                pops_q  <= '0;
                chk_q   <= '0;
                outst_q <= '0;
                vld_q   <= '0;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
                tmo_q   <= 1'b0;
                err_q   <= '0;
                ferr_q  <= '0;
            end
        end
    end

    // Command outputs follow the live command when issuing, otherwise hold the last one.
    assign addr_out          = (wr_issue || rd_issue) ? cur_addr : addr_q;
    assign mem.write         = wr_issue;
    assign mem.read          = rd_issue;
    assign mem.address       = addr_out;
    assign mem.writedata     = wr_issue ? wdata_c : wdata_q;
    assign mem.byteenable    = (wr_issue || rd_issue) ? '1 : be_q;
    assign mem.burstcount    = (wr_issue || rd_issue) ? BURSTCOUNT_WIDTH'(1) : bc_q;
    assign mem.readdata_sel  = addr_out[2:0];
    assign mem.read_ddr_data = pop;

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout_err    = tmo_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_mem_test_engine.sv
// Directed self-checking bench for mem_test_engine with a simple
// fixed-latency memory model behind the command interface.
module tb_mem_test_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [25:0] base_addr, num_words;
    logic [31:0] seed;
    logic        busy, done, pass, timeout_err;
    logic [15:0] err_count;
    logic [25:0] first_err_addr;

    int errors = 0;
    int checks = 0;

    mem_test_engine_if #(.DATA_WIDTH(64), .ADDR_WIDTH(26), .BYTEEN_WIDTH(8),
                         .BURSTCOUNT_WIDTH(7)) mif ();

    mem_test_engine #(
        .DATA_WIDTH(64), .ADDR_WIDTH(26), .BYTEEN_WIDTH(8),
        .BURSTCOUNT_WIDTH(7), .MAX_OUTSTANDING(16), .RD_LATENCY(4)
    ) dut (
        .Clk_400(clk), .SoftReset_n(rst_n), .start(start),
        .base_addr(base_addr), .num_words(num_words), .seed(seed),
`ifdef MEM_TEST_ERR_INJECT_EN
        .inject_err(1'b0),
`endif
        .mem(mif), .busy(busy), .done(done), .pass(pass),
        .timeout_err(timeout_err), .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    // Memory model and command monitor
    logic [63:0] mem_arr [logic [25:0]];
    logic [25:0] rq[$];
    logic [25:0] wr_addr[$], rd_addr[$];
    logic [63:0] wr_data[$];
    logic [2:0]  wr_sel[$], rd_sel[$];
    logic [63:0] dl[4];
    int          cyc = 0, wr_last_cyc = -1, rd_first_cyc = -1;
    int          both_hi = 0, wr_in_full = 0;
    bit          ready_en = 1'b1, corrupt_en = 1'b0;
    logic [25:0] corrupt_addr = 26'h0;

    always @(negedge clk) begin
        logic [25:0] a;
        logic [63:0] d;
        cyc++;
        if (mif.write) begin
            wr_addr.push_back(mif.address);
            wr_data.push_back(mif.writedata);
            wr_sel.push_back(mif.readdata_sel);
            mem_arr[mif.address] = mif.writedata;
            wr_last_cyc = cyc;
            if (mif.cmd_fifo_full) wr_in_full++;
        end
        if (mif.read) begin
            rd_addr.push_back(mif.address);
            rd_sel.push_back(mif.readdata_sel);
            rq.push_back(mif.address);
            if (rd_first_cyc < 0) rd_first_cyc = cyc;
        end
        if (mif.write && mif.read) both_hi++;
        for (int i = 3; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = '0;
        if (mif.read_ddr_data && rq.size() > 0) begin
            a = rq.pop_front();
            d = mem_arr.exists(a) ? mem_arr[a] : 64'h0;
            if (corrupt_en && a == corrupt_addr) d = d ^ 64'h1;
            dl[0] = d;
        end
    end

    always @(posedge clk) begin
        #1;
        mif.readdata       = dl[3];
        mif.ddr_data_ready = ready_en && (rq.size() > 0);
    end

    function automatic logic [63:0] pat(input logic [31:0] s, input logic [25:0] a);
        logic [31:0] w;
        w = s ^ {6'b0, a};
        return {w, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr.delete(); rd_addr.delete(); wr_data.delete();
        wr_sel.delete(); rd_sel.delete(); rq.delete(); mem_arr.delete();
        for (int i = 0; i < 4; i++) dl[i] = '0;
        wr_last_cyc = -1; rd_first_cyc = -1; both_hi = 0; wr_in_full = 0;
    endtask

    task automatic run_start(input logic [25:0] b, input logic [25:0] n, input logic [31:0] s);
        base_addr = b; num_words = n; seed = s; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin tick(); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait: done=%b required 1 within %0d cycles", name, done, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, pass, timeout_err, mif.write, mif.read, mif.read_ddr_data} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {busy, done, pass, timeout_err, mif.write, mif.read, mif.read_ddr_data});
        end
        checks++;
        if (err_count !== 16'h0 || first_err_addr !== 26'h0 || mif.address !== 26'h0 || mif.byteenable !== 8'h0) begin
            errors++;
            $display("FAIL reset_regs: err=%h ferr=%h addr=%h be=%h required all 0",
                     err_count, first_err_addr, mif.address, mif.byteenable);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_basic();
        int bad = 0;
        clear_logs();
        run_start(26'h100, 26'd8, 32'hA5A5A5A5);
        wait_done(200, "basic");
        checks++;
        if (wr_addr.size() != 8 || rd_addr.size() != 8) begin
            errors++;
            $display("FAIL basic_counts: writes=%0d reads=%0d required 8 8", wr_addr.size(), rd_addr.size());
        end
        foreach (wr_addr[i]) begin
            if (wr_addr[i] !== 26'h100 + 26'(i) || wr_data[i] !== pat(32'hA5A5A5A5, 26'h100 + 26'(i))) bad++;
        end
        foreach (rd_addr[i]) if (rd_addr[i] !== 26'h100 + 26'(i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_cmds: %0d bad addr/data entries required 0", bad); end
        checks++;
        if (!(rd_first_cyc > wr_last_cyc) || both_hi != 0) begin
            errors++;
            $display("FAIL basic_order: first_rd=%0d last_wr=%0d both_hi=%0d required rd after wr, 0",
                     rd_first_cyc, wr_last_cyc, both_hi);
        end
        checks++;
        if ({done, pass, busy, timeout_err} !== 4'b1100 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL basic_status: done/pass/busy/tmo=%b err=%0d required 1100 0",
                     {done, pass, busy, timeout_err}, err_count);
        end
    endtask

    task automatic test_stall();
        int bad = 0, n = 0;
        clear_logs();
        run_start(26'h200, 26'd12, 32'h12345678);
        while (wr_addr.size() < 3 && n < 50) begin tick(); n++; end
        mif.cmd_fifo_full = 1'b1;
        base_addr = 26'h999; num_words = 26'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (mif.write !== 1'b0 || mif.address !== wr_addr[wr_addr.size()-1]) begin
            errors++;
            $display("FAIL stall_hold: write=%b addr=%h required 0 %h", mif.write, mif.address,
                     wr_addr[wr_addr.size()-1]);
        end
        repeat (3) tick();
        mif.cmd_fifo_full = 1'b0;
        wait_done(200, "stall");
        foreach (wr_addr[i]) begin
            if (wr_addr[i] !== 26'h200 + 26'(i) || wr_data[i] !== pat(32'h12345678, 26'h200 + 26'(i))) bad++;
        end
        checks++;
        if (wr_addr.size() != 12 || bad != 0 || wr_in_full != 0) begin
            errors++;
            $display("FAIL stall_writes: count=%0d bad=%0d during_full=%0d required 12 0 0",
                     wr_addr.size(), bad, wr_in_full);
        end
        checks++;
        if (rd_addr.size() != 12 || pass !== 1'b1) begin
            errors++;
            $display("FAIL stall_result: reads=%0d pass=%b required 12 1", rd_addr.size(), pass);
        end
    endtask

    task automatic test_outstanding();
        clear_logs();
        ready_en = 1'b0;
        run_start(26'h400, 26'd40, 32'h0F0F1234);
        repeat (90) tick();
        checks++;
        if (rd_addr.size() != 16 || busy !== 1'b1 || mif.read !== 1'b0) begin
            errors++;
            $display("FAIL outst_limit: reads=%0d busy=%b read=%b required 16 1 0",
                     rd_addr.size(), busy, mif.read);
        end
        ready_en = 1'b1;
        wait_done(400, "outst");
        checks++;
        if (rd_addr.size() != 40 || pass !== 1'b1 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL outst_result: reads=%0d pass=%b err=%0d required 40 1 0",
                     rd_addr.size(), pass, err_count);
        end
    endtask

    task automatic test_corrupt();
        clear_logs();
        corrupt_en = 1'b1; corrupt_addr = 26'h103;
        run_start(26'h100, 26'd8, 32'hA5A5A5A5);
        wait_done(200, "corrupt");
        corrupt_en = 1'b0;
        checks++;
        if (err_count !== 16'd1 || first_err_addr !== 26'h103 || pass !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_result: err=%0d ferr=%h pass=%b required 1 103 0",
                     err_count, first_err_addr, pass);
        end
    endtask

    task automatic test_wrap();
        logic [25:0] ea[4];
        logic [2:0]  es[4];
        int bad = 0;
        ea = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0, 26'h1};
        es = '{3'd6, 3'd7, 3'd0, 3'd1};
        clear_logs();
        run_start(26'h3FFFFFE, 26'd4, 32'hDEADBEEF);
        wait_done(200, "wrap");
        checks++;
        if (wr_addr.size() != 4 || rd_addr.size() != 4) begin
            errors++;
            $display("FAIL wrap_counts: writes=%0d reads=%0d required 4 4", wr_addr.size(), rd_addr.size());
        end else begin
            for (int i = 0; i < 4; i++)
                if (wr_addr[i] !== ea[i] || rd_addr[i] !== ea[i] || wr_sel[i] !== es[i] || rd_sel[i] !== es[i]) bad++;
        end
        checks++;
        if (bad != 0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL wrap_addrs: %0d bad entries pass=%b required 0 1", bad, pass);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        clear_logs();
        run_start(26'h500, 26'd8, 32'h00C0FFEE);
        while (rd_addr.size() < 8 && n < 100) begin tick(); n++; end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_drain: busy=%b done=%b required 1 0", busy, done);
        end
        mif.ddr_read_timeout = 1'b1;
        #1;
        checks++;
        if (mif.read_ddr_data !== 1'b0 || mif.read !== 1'b0) begin
            errors++;
            $display("FAIL tmo_suppress: pop=%b read=%b required 0 0", mif.read_ddr_data, mif.read);
        end
        tick();
        mif.ddr_read_timeout = 1'b0;
        checks++;
        if ({busy, timeout_err, done, pass} !== 4'b0110) begin
            errors++;
            $display("FAIL tmo_abort: busy/tmo/done/pass=%b required 0110", {busy, timeout_err, done, pass});
        end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        clear_logs();
        run_start(26'h600, 26'd20, 32'h13579BDF);
        while (wr_addr.size() < 3 && n < 50) begin tick(); n++; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mif.write !== 1'b0 || busy !== 1'b0 || mif.address !== 26'h0) begin
            errors++;
            $display("FAIL rstmid_now: write=%b busy=%b addr=%h required 0 0 0", mif.write, busy, mif.address);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, pass, timeout_err} !== 4'b0 || wr_addr.size() != 3) begin
            errors++;
            $display("FAIL rstmid_after: busy/done/pass/tmo=%b writes=%0d required 0000 3",
                     {busy, done, pass, timeout_err}, wr_addr.size());
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        run_start(26'h700, 26'd0, 32'h11111111);
        checks++;
        if ({done, pass, busy} !== 3'b110) begin
            errors++;
            $display("FAIL zero_status: done/pass/busy=%b required 110", {done, pass, busy});
        end
        repeat (4) tick();
        checks++;
        if (wr_addr.size() != 0 || rd_addr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_cmds: writes=%0d reads=%0d busy=%b required 0 0 0",
                     wr_addr.size(), rd_addr.size(), busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
        mif.cmd_fifo_full = 1'b0; mif.ddr_write_timeout = 1'b0; mif.ddr_read_timeout = 1'b0;
        for (int i = 0; i < 4; i++) dl[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_outstanding();
        test_corrupt();
        test_wrap();
        test_timeout();
        test_reset_mid_write();
        test_zero_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
